// File: rtl/mul_sqrt_2_pkg.sv
// Shared constants and helpers for the x*sqrt(2) shift-add datapath.
package mul_sqrt_2_pkg;

    // Shift amounts of the sqrt(2) approximation: x + x>>>2 + x>>>3 + x>>>5 + x>>>7
    localparam int unsigned SQ2_SH [4] = '{2, 3, 5, 7};

    function automatic int unsigned width_of(input int unsigned n);
        return 32'(1) << n;
    endfunction

    function automatic logic [63:0] sat_max(input int unsigned n);
        return (64'(1) << (width_of(n) - 1)) - 64'(1);
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned n);
        return 64'(0) - (64'(1) << (width_of(n) - 1));
    endfunction

endpackage

// File: rtl/adder.sv
// Plain W-bit two's-complement adder; callers size W so it cannot overflow.
module adder #(
    parameter int unsigned W = 17
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum_c
);

    assign sum_c = a + b;

endmodule

// File: rtl/reg_n.sv
// W-bit register with load enable, cleared by asynchronous reset.
module reg_n #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sar_n.sv
// Constant arithmetic right shift (rounds toward minus infinity).
module sar_n #(
    parameter int unsigned W  = 17,
    parameter int unsigned SH = 1
) (
    input  logic signed [W-1:0] a,
    output logic signed [W-1:0] y_c
);

    assign y_c = a >>> SH;

endmodule

// File: rtl/sat_w1.sv
// Combinational saturation of a signed W+1 bit value to W bits with clip flag.
module sat_w1
    import mul_sqrt_2_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = width_of(N)
) (
    input  logic signed [W:0]   a,
    output logic signed [W-1:0] y_c,
    output logic                clip_c
);

    localparam logic [W-1:0] MAX_V = W'(sat_max(N));
    localparam logic [W-1:0] MIN_V = W'(sat_min(N));

    // Value fits in W bits exactly when the two top bits agree.
    always_comb begin
        y_c    = a[W-1:0];
        clip_c = 1'b0;
        if (a[W] != a[W-1]) begin
            clip_c = 1'b1;
            y_c    = a[W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/mul_sqrt_2.sv
// Three-stage valid/ready pipeline computing a saturated x*1.4140625 via shifts and adds.
module mul_sqrt_2
    import mul_sqrt_2_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = width_of(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sat
);

    localparam int unsigned W1 = W + 1;

    logic v1, v2, v3;
    logic adv1_c, adv2_c, adv3_c;

    logic signed [W1-1:0] xe;
    logic signed [W1-1:0] sh2_c, sh3_c, sh5_c, sh7_c;
    logic signed [W1-1:0] a_c, b_c, a_q, b_q, c_q;
    logic signed [W1-1:0] d_c, d_q, c2_q, e_c;
    logic signed [W-1:0]  sat_y_c;
    logic                 sat_clip_c;

    // A stage advances when it is empty or its successor advances.
    assign adv3_c    = ~v3 | out_ready;
    assign adv2_c    = ~v2 | adv3_c;
    assign adv1_c    = ~v1 | adv2_c;
    assign in_ready  = adv1_c;
    assign out_valid = v3;

    assign xe = {in[W-1], in};

    // Stage 1: partial sums a = x + x>>>2, b = x>>>3 + x>>>5, c = x>>>7
    sar_n #(.W(W1), .SH(SQ2_SH[0])) u_sh2 (.a(xe), .y_c(sh2_c));
    sar_n #(.W(W1), .SH(SQ2_SH[1])) u_sh3 (.a(xe), .y_c(sh3_c));
    sar_n #(.W(W1), .SH(SQ2_SH[2])) u_sh5 (.a(xe), .y_c(sh5_c));
    sar_n #(.W(W1), .SH(SQ2_SH[3])) u_sh7 (.a(xe), .y_c(sh7_c));

    adder #(.W(W1)) u_add_a (.a(xe),    .b(sh2_c), .sum_c(a_c));
    adder #(.W(W1)) u_add_b (.a(sh3_c), .b(sh5_c), .sum_c(b_c));

    reg_n #(.W(1))  u_v1  (.clk(clk), .rst(rst), .en(adv1_c), .d(in_valid), .q(v1));
    reg_n #(.W(W1)) u_a_q (.clk(clk), .rst(rst), .en(adv1_c), .d(a_c),      .q(a_q));
    reg_n #(.W(W1)) u_b_q (.clk(clk), .rst(rst), .en(adv1_c), .d(b_c),      .q(b_q));
    reg_n #(.W(W1)) u_c_q (.clk(clk), .rst(rst), .en(adv1_c), .d(sh7_c),    .q(c_q));

    // Stage 2: d = a + b, c carried along
    adder #(.W(W1)) u_add_d (.a(a_q), .b(b_q), .sum_c(d_c));

    reg_n #(.W(1))  u_v2   (.clk(clk), .rst(rst), .en(adv2_c), .d(v1),  .q(v2));
    reg_n #(.W(W1)) u_d_q  (.clk(clk), .rst(rst), .en(adv2_c), .d(d_c), .q(d_q));
    reg_n #(.W(W1)) u_c2_q (.clk(clk), .rst(rst), .en(adv2_c), .d(c_q), .q(c2_q));

    // Stage 3: final sum, saturate, register result
    adder #(.W(W1)) u_add_e (.a(d_q), .b(c2_q), .sum_c(e_c));

    sat_w1 #(.N(N)) u_sat (
        .a      (e_c),
        .y_c    (sat_y_c),
        .clip_c (sat_clip_c)
    );

    reg_n #(.W(1)) u_v3    (.clk(clk), .rst(rst), .en(adv3_c), .d(v2),         .q(v3));
    reg_n #(.W(W)) u_out   (.clk(clk), .rst(rst), .en(adv3_c), .d(sat_y_c),    .q(out));
    reg_n #(.W(1)) u_o_sat (.clk(clk), .rst(rst), .en(adv3_c), .d(sat_clip_c), .q(out_sat));

endmodule

// File: tb/tb_mul_sqrt_2.sv
// Scoreboard bench for mul_sqrt_2 (N = 4): reference model, directed corners and random traffic.
module tb_mul_sqrt_2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] out;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               out_sat;

    logic [16:0] exp_q[$];
    logic [16:0] exp_e;
    int checks = 0;
    int errors = 0;
    int pops   = 0;

    mul_sqrt_2 #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer shift-add sum, then clip to 16-bit range.
    function automatic logic [16:0] model(input int x);
        logic signed [15:0] xs;
        int xi, y;
        xs = 16'(x);
        xi = xs;
        y  = xi + (xi >>> 2) + (xi >>> 3) + (xi >>> 5) + (xi >>> 7);
        if (y > 32767)  return {1'b1, 16'h7fff};
        if (y < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(y)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops and compares one expected result.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", out);
            end else begin
                exp_e = exp_q.pop_front();
                chk("out", longint'(out), longint'($signed(exp_e[15:0])));
                chk("out_sat", longint'(out_sat), longint'(exp_e[16]));
            end
        end
    end

    // One cycle of stimulus; records an accepted input in the scoreboard.
    task automatic step(input int x, input logic vld, input logic rdy, output logic acc);
        @(negedge clk);
        in        = 16'(x);
        in_valid  = vld;
        out_ready = rdy;
        #1;
        acc = vld && in_ready;
        if (acc) exp_q.push_back(model(x));
    endtask

    task automatic send(input int x, input logic rdy);
        logic acc;
        for (int k = 0; k < 20; k++) begin
            step(x, 1'b1, rdy, acc);
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc;
        repeat (8) step(0, 1'b0, 1'b1, acc);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Lone sample into an empty pipe: out_valid must rise after the third edge.
    task automatic latency(input int x);
        logic acc;
        step(x, 1'b1, 1'b1, acc);
        chk("lat_accept", acc, 1);
        for (int k = 1; k <= 3; k++) begin
            step(0, 1'b0, 1'b1, acc);
            chk("latency_out_valid", out_valid, (k == 3) ? 1 : 0);
        end
    endtask

    initial begin
        logic acc;
        int   idx, p0, x;
        int   dir_vals[8] = '{1000, -1000, 23170, 23175, 32767, -32768, 0, -1};

        // Reset state
        #2 rst = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", out, 0);
        chk("rst_out_sat", out_sat, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        latency(1000);
        for (int i = 0; i < 8; i++) send(dir_vals[i], 1'b1);
        drain();

        // Back-pressure: stream 1..5 with out_ready low for six cycles
        p0  = pops;
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            step(idx, 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepts", idx - 1, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_hold", out, 1);
        step(idx, 1'b1, 1'b1, acc);
        chk("release_in_ready", acc, 1);
        idx++;
        send(5, 1'b1);
        drain();
        chk("bp_count", pops - p0, 5);

        // Bubble collapse while the last stage is stalled
        step(7, 1'b1, 1'b0, acc);
        step(0, 1'b0, 1'b0, acc);
        step(0, 1'b0, 1'b0, acc);
        step(9, 1'b1, 1'b0, acc);
        chk("bubble_accept", acc, 1);
        step(0, 1'b0, 1'b0, acc);
        chk("bubble_ready_s1", in_ready, 1);
        step(0, 1'b0, 1'b0, acc);
        chk("bubble_ready_s2", in_ready, 1);
        step(11, 1'b1, 1'b0, acc);
        chk("bubble_accept2", acc, 1);
        step(0, 1'b0, 1'b0, acc);
        chk("bubble_full", in_ready, 0);
        drain();

        // Asynchronous reset with three samples in flight
        step(100, 1'b1, 1'b0, acc);
        step(200, 1'b1, 1'b0, acc);
        step(300, 1'b1, 1'b0, acc);
        step(0, 1'b0, 1'b0, acc);
        chk("pre_rst_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        latency(-1000);
        drain();

        // Random traffic with occasional extreme values
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) x = dir_vals[$urandom_range(0, 7)];
            else x = int'($signed(16'($urandom)));
            step(x, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
